bitty_ctrl: RTL and testbench

//  Control sequencer that drives the bitty datapath ALU: accepts one 16-bit instruction per

---
 rtl/bitty_ctrl_if.sv | 27 ++
 rtl/bitty_ctrl.sv | 128 ++++++++++++
 tb/tb_bitty_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/bitty_ctrl_if.sv
// Instruction handshake and datapath control bundle for the bitty controller.
// The master modport is the fetch/datapath side; the slave modport is the controller.
interface bitty_ctrl_if #(
  parameter int NUM_REGS = 8
);
  logic [15:0]         instr;
  logic                instr_valid;
  logic                instr_ready;
  logic [3:0]          mux_sel;
  logic [15:0]         imm_out;
  logic                en_s;
  logic                en_c;
  logic [2:0]          alu_sel;
  logic [NUM_REGS-1:0] en_reg;
  logic                done;
  logic                illegal;

  modport master (
    output instr, instr_valid,
    input  instr_ready, mux_sel, imm_out, en_s, en_c, alu_sel, en_reg, done, illegal
  );

  modport slave (
    input  instr, instr_valid,
    output instr_ready, mux_sel, imm_out, en_s, en_c, alu_sel, en_reg, done, illegal
  );
endinterface

// File: rtl/bitty_ctrl.sv
// Moore control sequencer for the bitty ALU datapath: load A, load B, write back.
// Optional macro BITTY_CTRL_CMP_NOWB_EN suppresses the register write for compare ops.
module bitty_ctrl #(
  parameter int NUM_REGS  = 8,
  parameter int IMM_WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  bitty_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    WB,
    RETIRE
  } state_t;

  localparam logic [1:0] FMT_R   = 2'b00;
  localparam logic [1:0] FMT_I   = 2'b01;
  localparam logic [1:0] FMT_RSV = 2'b11;
  localparam logic [3:0] SEL_IMM = 4'd8;

  state_t              state;
  state_t              state_next;
  logic [15:0]         instr_q;
  logic                accept;

  logic [2:0]          rx;
  logic [2:0]          ry;
  logic [2:0]          op_sel;
  logic [1:0]          fmt;
  logic [NUM_REGS-1:0] rx_onehot;

  logic                instr_ready;
  logic [3:0]          mux_sel;
  logic                en_s;
  logic                en_c;
  logic [NUM_REGS-1:0] en_reg;
  logic                done;
  logic                illegal;

  assign accept = bus.instr_valid && (state == IDLE);

  assign rx        = instr_q[15:13];
  assign ry        = instr_q[12:10];
  assign op_sel    = instr_q[4:2];
  assign fmt       = instr_q[1:0];
  assign rx_onehot = NUM_REGS'(1) << rx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      instr_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        instr_q <= bus.instr;
      end
    end
  end

  // Branch on the incoming word's format since the latch only updates at this edge.
  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    mux_sel     = 4'd0;
    en_s        = 1'b0;
    en_c        = 1'b0;
    en_reg      = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    unique case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (accept) begin
          state_next = bus.instr[1] ? RETIRE : LOAD_A;
        end
      end
      LOAD_A: begin
        mux_sel    = {1'b0, rx};
        en_s       = 1'b1;
        state_next = LOAD_B;
      end
      LOAD_B: begin
        mux_sel    = (fmt == FMT_I) ? SEL_IMM : {1'b0, ry};
        en_c       = 1'b1;
        state_next = WB;
      end
      WB: begin
        done = 1'b1;
`ifdef BITTY_CTRL_CMP_NOWB_EN
        // Compare results stay on alu_out only; rx keeps its old value.
        if (op_sel != 3'b111) begin
          en_reg = rx_onehot;
        end
`else
        en_reg = rx_onehot;
`endif
        state_next = IDLE;
      end
      RETIRE: begin
        done       = 1'b1;
        illegal    = (fmt == FMT_RSV);
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.instr_ready = instr_ready;
  assign bus.mux_sel     = mux_sel;
  assign bus.imm_out     = {{(16-IMM_WIDTH){1'b0}}, instr_q[5 +: IMM_WIDTH]};
  assign bus.en_s        = en_s;
  assign bus.en_c        = en_c;
  assign bus.alu_sel     = op_sel;
  assign bus.en_reg      = en_reg;
  assign bus.done        = done;
  assign bus.illegal     = illegal;

  // R-type format constant kept for readability of the decode above.
  logic unused_fmt_r;
  assign unused_fmt_r = ^FMT_R;

endmodule

// File: tb/tb_bitty_ctrl.sv
// Directed self-checking bench for bitty_ctrl with hand-computed expected values.
// Compare writeback expectation follows BITTY_CTRL_CMP_NOWB_EN.
module tb_bitty_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  bitty_ctrl_if #(.NUM_REGS(8)) bus ();

  bitty_ctrl #(.NUM_REGS(8), .IMM_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word for a single edge; returns one cycle after the accept edge.
  task automatic applyStimulus(input logic [15:0] word);
    checkOutput("ready_before_accept", {31'd0, bus.instr_ready}, 32'd1);
    bus.instr       = word;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ready"}, {31'd0, bus.instr_ready}, 32'd1);
    checkOutput({tag, "_mux"},   {28'd0, bus.mux_sel}, 32'd0);
    checkOutput({tag, "_ensc"},  {30'd0, bus.en_s, bus.en_c}, 32'd0);
    checkOutput({tag, "_enreg"}, {24'd0, bus.en_reg}, 32'd0);
    checkOutput({tag, "_done"},  {30'd0, bus.done, bus.illegal}, 32'd0);
  endtask

  logic [15:0] words [3];
  int          accept_cycle [3];
  int          n_accept;
  int          n_done;
  logic [7:0]  enreg_or;
  logic        ready_before;

  initial begin
    total = 0;
    bad   = 0;
    bus.instr       = 16'h0000;
    bus.instr_valid = 1'b0;
    reset = 1'b1;
    #3;
    checkIdleOutputs("reset");
    checkOutput("reset_imm",  {16'd0, bus.imm_out}, 32'd0);
    checkOutput("reset_alu",  {29'd0, bus.alu_sel}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // R-type add with rx == ry == 1
    applyStimulus(16'h2400);
    checkOutput("add_la_mux",  {28'd0, bus.mux_sel}, 32'd1);
    checkOutput("add_la_ens",  {30'd0, bus.en_s, bus.en_c}, 32'd2);
    checkOutput("add_la_rdy",  {31'd0, bus.instr_ready}, 32'd0);
    step();
    checkOutput("add_lb_mux",  {28'd0, bus.mux_sel}, 32'd1);
    checkOutput("add_lb_enc",  {30'd0, bus.en_s, bus.en_c}, 32'd1);
    checkOutput("add_lb_done", {31'd0, bus.done}, 32'd0);
    step();
    checkOutput("add_wb_enreg", {24'd0, bus.en_reg}, 32'h02);
    checkOutput("add_wb_done",  {30'd0, bus.done, bus.illegal}, 32'd2);
    checkOutput("add_wb_alu",   {29'd0, bus.alu_sel}, 32'd0);
    step();
    checkIdleOutputs("add_after");

    // I-type sub: rx=3, imm=A5, sel=001, fmt=01
    applyStimulus(16'h74A5);
    checkOutput("sub_la_mux", {28'd0, bus.mux_sel}, 32'd3);
    checkOutput("sub_imm",    {16'd0, bus.imm_out}, 32'h00A5);
    step();
    checkOutput("sub_lb_mux", {28'd0, bus.mux_sel}, 32'd8);
    checkOutput("sub_lb_enc", {30'd0, bus.en_s, bus.en_c}, 32'd1);
    checkOutput("sub_lb_alu", {29'd0, bus.alu_sel}, 32'd1);
    step();
    checkOutput("sub_wb_enreg", {24'd0, bus.en_reg}, 32'h08);
    checkOutput("sub_wb_alu",   {29'd0, bus.alu_sel}, 32'd1);
    checkOutput("sub_wb_done",  {31'd0, bus.done}, 32'd1);
    step();

    // Reserved format retires one cycle after accept
    applyStimulus(16'hFFFF);
    checkOutput("rsv_done",  {30'd0, bus.done, bus.illegal}, 32'd3);
    checkOutput("rsv_enreg", {24'd0, bus.en_reg}, 32'd0);
    checkOutput("rsv_mux",   {28'd0, bus.mux_sel}, 32'd0);
    step();
    checkIdleOutputs("rsv_after");

    // NOP retires without illegal
    applyStimulus(16'h0002);
    checkOutput("nop_done",  {30'd0, bus.done, bus.illegal}, 32'd2);
    checkOutput("nop_enreg", {24'd0, bus.en_reg}, 32'd0);
    step();

    // Compare rx=5, ry=2, sel=111
    applyStimulus(16'hA81C);
    step();
    step();
    checkOutput("cmp_wb_done", {31'd0, bus.done}, 32'd1);
    checkOutput("cmp_wb_alu",  {29'd0, bus.alu_sel}, 32'd7);
`ifdef BITTY_CTRL_CMP_NOWB_EN
    checkOutput("cmp_wb_enreg", {24'd0, bus.en_reg}, 32'h00);
`else
    checkOutput("cmp_wb_enreg", {24'd0, bus.en_reg}, 32'h20);
`endif
    step();

    // Back-to-back with instr_valid held high
    words[0] = 16'h2400;
    words[1] = 16'h4800;
    words[2] = 16'hC00C;
    n_accept = 0;
    n_done   = 0;
    enreg_or = 8'h00;
    bus.instr       = words[0];
    bus.instr_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      ready_before = bus.instr_ready;
      step();
      if (bus.done) n_done++;
      enreg_or = enreg_or | bus.en_reg;
      if (ready_before && bus.instr_valid) begin
        if (n_accept < 3) accept_cycle[n_accept] = c;
        n_accept++;
        if (n_accept >= 3) bus.instr_valid = 1'b0;
        else bus.instr = words[n_accept];
      end
    end
    checkOutput("b2b_accepts", n_accept, 32'd3);
    checkOutput("b2b_gap1", accept_cycle[1] - accept_cycle[0], 32'd4);
    checkOutput("b2b_gap2", accept_cycle[2] - accept_cycle[1], 32'd4);
    checkOutput("b2b_dones", n_done, 32'd3);
    checkOutput("b2b_enreg", {24'd0, enreg_or}, 32'h46);

    // Asynchronous reset in the middle of LOAD_B
    applyStimulus(16'h2400);
    step();
    checkOutput("rst_pre_enc", {31'd0, bus.en_c}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkIdleOutputs("rst_mid");
    checkOutput("rst_mid_alu", {29'd0, bus.alu_sel}, 32'd0);
    step();
    checkOutput("rst_hold_enreg", {24'd0, bus.en_reg}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    checkIdleOutputs("rst_after");
    step();
    checkOutput("rst_after2_enreg", {24'd0, bus.en_reg}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
